// File: rtl/bit_pop_pkg.sv
// Shared types and helpers for the bit population enumerator.
//   state_e     : controller state (IDLE waits for a request, RUN streams words)
//   count_width : width of the requested-k port, $clog2(width)+1, so k=width fits
package bit_pop_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int unsigned count_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/bit_population_enumerator_lsb_index.sv
// Lowest-set-bit index (trailing-zero count) of a word; combinational.
//   data_i  : WIDTH-bit word
//   index_o : index of the lowest set bit, 0 when data_i is zero
module lsb_index #(
    parameter int unsigned WIDTH = 24
) (
    input  logic [WIDTH-1:0]         data_i,
    output logic [$clog2(WIDTH)-1:0] index_o
);

    localparam int unsigned IW = $clog2(WIDTH);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        index_o = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (data_i[i]) begin
                index_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/bit_population_enumerator.sv
// Streams every WIDTH-bit word with exactly k ones, ascending, one word per
// accepted handshake.
//   clk_i / srst_i              : clock, synchronous active-high reset
//   count_i / count_val_i       : requested k and its valid
//   count_ready_o               : idle and able to take a new k
//   data_o / data_val_o         : current word and its valid
//   data_ready_i                : downstream accepts data_o
//   data_last_o                 : data_o is the final word of this k
//   err_o                       : one-cycle pulse for an illegal k (k > WIDTH)
module bit_population_enumerator
    import bit_pop_pkg::*;
#(
    parameter int unsigned WIDTH = 24
) (
    input  logic                          clk_i,
    input  logic                          srst_i,
    input  logic [count_width(WIDTH)-1:0] count_i,
    input  logic                          count_val_i,
    output logic                          count_ready_o,
    output logic [WIDTH-1:0]              data_o,
    output logic                          data_val_o,
    input  logic                          data_ready_i,
    output logic                          data_last_o,
    output logic                          err_o
);

    localparam int unsigned IW = $clog2(WIDTH);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] top_mask_q;
    logic [WIDTH-1:0] top_mask_d;
    logic             val_q;
    logic             val_d;
    logic             last_q;
    logic             last_d;
    logic             err_q;
    logic             err_d;
    logic             ready_q;
    logic             ready_d;

    logic             accept;
    logic             k_legal;
    logic             xfer;
    logic [WIDTH-1:0] low_bit;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [IW-1:0]    tz;
    logic [WIDTH-1:0] next_word;
    logic [WIDTH-1:0] first_word;
    logic [WIDTH-1:0] req_top_mask;

    assign accept  = (state_q == IDLE) && ready_q && count_val_i;
    assign k_legal = (32'(count_i) <= WIDTH);
    assign xfer    = (state_q == RUN) && val_q && data_ready_i;

    // Next combination of the same popcount (Gosper's step).
    lsb_index #(
        .WIDTH (WIDTH)
    ) u_lsb_index (
        .data_i  (data_q),
        .index_o (tz)
    );

    assign low_bit   = data_q & (~data_q + WIDTH'(1));
    // One extra bit so the carry out of the add never folds back into the word.
    assign sum       = {1'b0, data_q} + {1'b0, low_bit};
    assign diff      = sum ^ {1'b0, data_q};
    assign next_word = sum[WIDTH-1:0] | WIDTH'(diff >> (32'(tz) + 32'd2));

    // First word is k ones at the bottom; the last is k ones at the top.
    assign first_word   = WIDTH'(((WIDTH+1)'(1) << count_i) - (WIDTH+1)'(1));
    assign req_top_mask = ~WIDTH'(((WIDTH+1)'(1) << (32'(WIDTH) - 32'(count_i)))
                                  - (WIDTH+1)'(1));

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q    <= IDLE;
            data_q     <= '0;
            top_mask_q <= '0;
            val_q      <= 1'b0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            top_mask_q <= top_mask_d;
            val_q      <= val_d;
            last_q     <= last_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
        end
    end

    // Next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && k_legal) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (xfer && last_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and word datapath.
    always_comb begin
        data_d     = data_q;
        top_mask_d = top_mask_q;
        val_d      = val_q;
        last_d     = last_q;
        err_d      = 1'b0;
        ready_d    = ready_q;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                val_d   = 1'b0;
                last_d  = 1'b0;
                if (accept) begin
                    if (k_legal) begin
                        data_d     = first_word;
                        top_mask_d = req_top_mask;
                        val_d      = 1'b1;
                        last_d     = (first_word == req_top_mask);
                        ready_d    = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (xfer) begin
                    if (last_q) begin
                        val_d   = 1'b0;
                        last_d  = 1'b0;
                        ready_d = 1'b1;
                    end else begin
                        data_d = next_word;
                        last_d = (next_word == top_mask_q);
                    end
                end
            end
            default: begin
                val_d   = 1'b0;
                last_d  = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    assign count_ready_o = ready_q;
    assign data_o        = data_q;
    assign data_val_o    = val_q;
    assign data_last_o   = last_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_bit_population_enumerator.sv
// Scoreboard bench: a WIDTH=4 instance for the directed/random handshake cases
// and a WIDTH=24 instance for the full k=3 enumeration.
module tb_bit_population_enumerator;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        srst = 1'b1;

    logic [2:0]  k4 = '0;
    logic        kval4 = 1'b0;
    logic        rdy4;
    logic [3:0]  dat4;
    logic        dval4;
    logic        dready4 = 1'b1;
    logic        last4;
    logic        err4;

    logic [5:0]  k24 = '0;
    logic        kval24 = 1'b0;
    logic        rdy24;
    logic [23:0] dat24;
    logic        dval24;
    logic        dready24 = 1'b1;
    logic        last24;
    logic        err24;

    exp_t q4[$];
    exp_t q24[$];
    int   err_exp4 = 0;
    int   xfer4 = 0;
    int   xfer24 = 0;
    bit   rand_rdy = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bit_population_enumerator #(.WIDTH(4)) u_dut4 (
        .clk_i         (clk),
        .srst_i        (srst),
        .count_i       (k4),
        .count_val_i   (kval4),
        .count_ready_o (rdy4),
        .data_o        (dat4),
        .data_val_o    (dval4),
        .data_ready_i  (dready4),
        .data_last_o   (last4),
        .err_o         (err4)
    );

    bit_population_enumerator #(.WIDTH(24)) u_dut24 (
        .clk_i         (clk),
        .srst_i        (srst),
        .count_i       (k24),
        .count_val_i   (kval24),
        .count_ready_o (rdy24),
        .data_o        (dat24),
        .data_val_o    (dval24),
        .data_ready_i  (dready24),
        .data_last_o   (last24),
        .err_o         (err24)
    );

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference for WIDTH=4: all words with popcount k, in numeric order.
    task automatic model4(input int k);
        int tot;
        int n;
        logic [3:0] v;
        exp_t e;
        if (k > 4) begin
            err_exp4++;
        end else begin
            tot = 0;
            for (int i = 0; i < 16; i++) begin
                v = 4'(i);
                if ($countones(v) == k) tot++;
            end
            n = 0;
            for (int i = 0; i < 16; i++) begin
                v = 4'(i);
                if ($countones(v) == k) begin
                    n++;
                    e.data = 32'(v);
                    e.last = (n == tot);
                    q4.push_back(e);
                end
            end
        end
    endtask

    // Reference for WIDTH=24, k=3: bit triples h>m>l, ascending by h, then m, then l.
    task automatic model24_k3();
        exp_t e;
        for (int h = 2; h < 24; h++)
            for (int m = 1; m < h; m++)
                for (int l = 0; l < m; l++) begin
                    e.data = (32'd1 << h) | (32'd1 << m) | (32'd1 << l);
                    e.last = (h == 23 && m == 22 && l == 21);
                    q24.push_back(e);
                end
    endtask

    task automatic mon4();
        exp_t e;
        bit held = 1'b0;
        logic [3:0] pd = '0;
        logic pl = 1'b0;
        forever begin
            @(negedge clk);
            if (srst) begin
                held = 1'b0;
                continue;
            end
            if (err4) begin
                chk(err_exp4 > 0, "err4_unexpected", 32'(err4), 32'd0);
                if (err_exp4 > 0) err_exp4--;
            end
            if (dval4) begin
                if (held) chk({pd, pl} == {dat4, last4}, "hold4", 32'({dat4, last4}), 32'({pd, pl}));
                if (q4.size() == 0) begin
                    chk(1'b0, "spurious_valid4", 32'(dat4), 32'd0);
                end else if (dready4) begin
                    e = q4.pop_front();
                    chk(dat4 == e.data[3:0], "data4", 32'(dat4), e.data);
                    chk(last4 == e.last, "last4", 32'(last4), 32'(e.last));
                    xfer4++;
                end
                held = dval4 && !dready4;
                pd = dat4;
                pl = last4;
            end else begin
                held = 1'b0;
            end
        end
    endtask

    task automatic mon24();
        exp_t e;
        bit have_prev = 1'b0;
        logic [23:0] prev = '0;
        forever begin
            @(negedge clk);
            if (srst) continue;
            if (err24) chk(1'b0, "err24_unexpected", 32'(err24), 32'd0);
            if (dval24) begin
                if (q24.size() == 0) begin
                    chk(1'b0, "spurious_valid24", 32'(dat24), 32'd0);
                end else if (dready24) begin
                    e = q24.pop_front();
                    chk(dat24 == e.data[23:0], "data24", 32'(dat24), e.data);
                    chk(last24 == e.last, "last24", 32'(last24), 32'(e.last));
                    chk($countones(dat24) == 3, "popcount24", 32'($countones(dat24)), 32'd3);
                    if (have_prev) chk(dat24 > prev, "ascending24", 32'(dat24), 32'(prev));
                    prev = dat24;
                    have_prev = !last24;
                    xfer24++;
                end
            end
        end
    endtask

    task automatic rand_ready_drv();
        forever begin
            @(posedge clk);
            #2;
            if (rand_rdy) dready4 = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_rdy4();
        int n = 0;
        while (!rdy4 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(rdy4 == 1'b1, "wait_ready4", 32'(rdy4), 32'd1);
    endtask

    // Issue k on the WIDTH=4 instance and wait for idle; cycles = polls to idle.
    task automatic do_req4(input int k, output int cycles);
        model4(k);
        wait_rdy4();
        k4 = 3'(k);
        kval4 = 1'b1;
        @(posedge clk);
        #1;
        kval4 = 1'b0;
        cycles = 0;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk);
            #1;
            if (q4.size() == 0 && err_exp4 == 0 && rdy4 && !dval4) begin
                cycles = c;
                break;
            end
        end
        if (cycles == 0) chk(1'b0, "done4_timeout", 32'(q4.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int base;
        fork
            mon4();
            mon24();
            rand_ready_drv();
        join_none

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk({rdy4, dval4, last4, err4, dat4} == '0, "reset4_outputs",
            32'({rdy4, dval4, last4, err4, dat4}), 32'd0);
        chk({rdy24, dval24, last24, err24, dat24} == '0, "reset24_outputs",
            32'({rdy24, dval24, last24, err24, dat24}), 32'd0);
        srst = 1'b0;
        @(posedge clk);
        #1;
        chk(rdy4 == 1'b1, "ready4_after_reset", 32'(rdy4), 32'd1);
        chk(rdy24 == 1'b1, "ready24_after_reset", 32'(rdy24), 32'd1);

        // k=2 at full throughput: six words on six consecutive cycles.
        do_req4(2, cyc);
        chk(cyc == 6, "k2_cycles", 32'(cyc), 32'd6);

        // k=0 and k=WIDTH: one word each, ready again on the next cycle.
        do_req4(0, cyc);
        chk(cyc == 1, "k0_cycles", 32'(cyc), 32'd1);
        do_req4(4, cyc);
        chk(cyc == 1, "k4_cycles", 32'(cyc), 32'd1);

        // Illegal k: error pulse, no data, ready stays high.
        do_req4(5, cyc);
        chk(cyc == 1, "k5_cycles", 32'(cyc), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk(rdy4 && !dval4, "k5_idle", 32'({rdy4, dval4}), 32'b10);
            @(posedge clk);
            #1;
        end

        // k=1 under random backpressure.
        rand_rdy = 1'b1;
        do_req4(1, cyc);
        rand_rdy = 1'b0;
        dready4 = 1'b1;
        @(posedge clk);
        #1;

        // k=2 aborted by reset after the second transfer, then k=3.
        base = xfer4;
        model4(2);
        wait_rdy4();
        k4 = 3'd2;
        kval4 = 1'b1;
        @(posedge clk);
        #1;
        kval4 = 1'b0;
        for (int i = 0; i < 50 && xfer4 != base + 2; i++) begin
            @(posedge clk);
            #1;
        end
        chk(xfer4 == base + 2, "abort_two_words", 32'(xfer4 - base), 32'd2);
        srst = 1'b1;
        q4.delete();
        @(posedge clk);
        #1;
        chk({rdy4, dval4, last4, err4, dat4} == '0, "abort_reset_outputs",
            32'({rdy4, dval4, last4, err4, dat4}), 32'd0);
        srst = 1'b0;
        @(posedge clk);
        #1;
        chk(rdy4 && !dval4, "abort_ready_after", 32'({rdy4, dval4}), 32'b10);
        do_req4(3, cyc);
        chk(cyc == 4, "k3_cycles", 32'(cyc), 32'd4);

        // WIDTH=24, k=3: all 2024 combinations.
        base = xfer24;
        model24_k3();
        k24 = 6'd3;
        kval24 = 1'b1;
        @(posedge clk);
        #1;
        kval24 = 1'b0;
        for (int i = 0; i < 3000 && !(q24.size() == 0 && rdy24 && !dval24); i++) begin
            @(posedge clk);
            #1;
        end
        chk(xfer24 - base == 2024, "k3_w24_count", 32'(xfer24 - base), 32'd2024);
        chk(rdy24 == 1'b1, "k3_w24_ready", 32'(rdy24), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk(q4.size() == 0, "q4_drained", 32'(q4.size()), 32'd0);
        chk(q24.size() == 0, "q24_drained", 32'(q24.size()), 32'd0);
        chk(err_exp4 == 0, "err4_seen", 32'(err_exp4), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
